// File: rtl/axi_sram_arbiter.sv
// Bridges an instruction read port and a data read/write port onto one AXI3 master.
// One single-beat transaction is in flight at a time; the data port has priority.
module axi_sram_arbiter #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clock,
  input  logic        reset,
  // instruction port
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic [31:0] inst_rdata,
  output logic        inst_data_ok,
  // data port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic [31:0] data_rdata,
  output logic        data_data_ok,
  // AXI read address
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address / data / response
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {StIdle, StAr, StR, StW, StB} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic        owner_q;  // 1: data port owns the transaction
  logic        aw_done_q, w_done_q;

  logic live, take_data, take_inst, aw_hs, w_hs;

  // Response fields and rlast carry nothing a single-beat master needs.
  logic unused_inputs;
  assign unused_inputs = ^{rid, rresp, rlast, bid, bresp};

  assign live      = !reset;
  assign take_data = (state_q == StIdle) && data_req;
  assign take_inst = (state_q == StIdle) && inst_req && !data_req;
  assign aw_hs     = (state_q == StW) && !aw_done_q && awready;
  assign w_hs      = (state_q == StW) && !w_done_q && wready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (take_data)      state_d = data_wr ? StW : StAr;
        else if (take_inst) state_d = StAr;
      end
      StAr: if (arready) state_d = StR;
      StR:  if (rvalid) state_d = StIdle;
      StW:  if ((aw_done_q || awready) && (w_done_q || wready)) state_d = StB;
      StB:  if (bvalid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      owner_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take_data || take_inst) begin
        addr_q    <= take_data ? data_addr : inst_addr;
        size_q    <= take_data ? data_size : 2'd2;
        wdata_q   <= data_wdata;
        owner_q   <= take_data;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else begin
        if (aw_hs) aw_done_q <= 1'b1;
        if (w_hs)  w_done_q  <= 1'b1;
      end
    end
  end

  assign inst_addr_ok = live && take_inst;
  assign data_addr_ok = live && take_data;

  assign arvalid = live && (state_q == StAr);
  assign rready  = live && (state_q == StR);
  assign awvalid = live && (state_q == StW) && !aw_done_q;
  assign wvalid  = live && (state_q == StW) && !w_done_q;
  assign bready  = live && (state_q == StB);

  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;
  assign inst_data_ok = rready && rvalid && !owner_q;
  assign data_data_ok = (rready && rvalid && owner_q) || (bready && bvalid);

  assign arid    = live ? (owner_q ? DATA_ID : INST_ID) : 4'd0;
  assign araddr  = addr_q;
  assign arlen   = 4'd0;
  assign arsize  = {1'b0, size_q};
  assign arburst = 2'b01;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign awid    = live ? DATA_ID : 4'd0;
  assign awaddr  = addr_q;
  assign awlen   = 4'd0;
  assign awsize  = {1'b0, size_q};
  assign awburst = 2'b01;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;

  assign wid   = live ? DATA_ID : 4'd0;
  assign wdata = wdata_q;
  assign wlast = 1'b1;

  always_comb begin
    wstrb = 4'b1111;
    case (size_q)
      2'd0:    wstrb = 4'b0001 << addr_q[1:0];
      2'd1:    wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
      default: wstrb = 4'b1111;
    endcase
  end

endmodule

// File: tb/tb_axi_sram_arbiter.sv
// Bench for axi_sram_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model.
module tb_axi_sram_arbiter;

  localparam logic [3:0] InstId = 4'd0;
  localparam logic [3:0] DataId = 4'd1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req = 1'b0, data_req = 1'b0, data_wr = 1'b0;
  logic [31:0] inst_addr = '0, data_addr = '0, data_wdata = '0;
  logic [1:0]  data_size = '0;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb;
  logic [31:0] araddr, awaddr, wdata;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock;
  logic        arvalid, rready, awvalid, wvalid, wlast, bready;
  logic        arready = 1'b0, rvalid = 1'b0, rlast = 1'b1, awready = 1'b0, wready = 1'b0;
  logic        bvalid = 1'b0;
  logic [3:0]  rid = '0, bid = '0;
  logic [1:0]  rresp = '0, bresp = '0;
  logic [31:0] rdata = '0;

  always #5 clock = ~clock;

  axi_sram_arbiter #(.INST_ID(InstId), .DATA_ID(DataId)) dut (
    .clock(clock), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_rdata(data_rdata),
    .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_strb(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'd0:    return 4'b0001 << a;
      2'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Model: one outstanding transaction record plus which channel handshakes are done.
  logic        m_busy = 1'b0, m_data = 1'b0, m_wr = 1'b0;
  logic        m_ar = 1'b0, m_aw = 1'b0, m_w = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [1:0]  m_size = '0;
  logic        acc_data = 1'b0, acc_inst = 1'b0;

  always @(posedge clock) begin
    acc_data <= 1'b0;
    acc_inst <= 1'b0;
    if (reset) begin
      m_busy <= 1'b0;
    end else if (!m_busy) begin
      m_ar <= 1'b0;
      m_aw <= 1'b0;
      m_w  <= 1'b0;
      if (data_req) begin
        acc_data <= 1'b1; m_busy <= 1'b1; m_data <= 1'b1; m_wr <= data_wr;
        m_addr <= data_addr; m_size <= data_size; m_wdata <= data_wdata;
      end else if (inst_req) begin
        acc_inst <= 1'b1; m_busy <= 1'b1; m_data <= 1'b0; m_wr <= 1'b0;
        m_addr <= inst_addr; m_size <= 2'd2;
      end
    end else if (!m_wr) begin
      if (!m_ar) m_ar <= arready;
      else if (rvalid) m_busy <= 1'b0;
    end else if (m_aw && m_w) begin
      if (bvalid) m_busy <= 1'b0;
    end else begin
      if (awready) m_aw <= 1'b1;
      if (wready)  m_w  <= 1'b1;
    end
  end

  logic e_iaok, e_daok, e_arv, e_rr, e_iok, e_dok, e_awv, e_wv, e_br;
  always_comb begin
    e_iaok = 1'b0; e_daok = 1'b0; e_arv = 1'b0; e_rr = 1'b0; e_iok = 1'b0;
    e_dok  = 1'b0; e_awv  = 1'b0; e_wv  = 1'b0; e_br = 1'b0;
    if (!reset) begin
      if (!m_busy) begin
        e_daok = data_req;
        e_iaok = inst_req && !data_req;
      end else if (!m_wr) begin
        e_arv = !m_ar;
        e_rr  = m_ar;
        e_dok = m_ar && rvalid && m_data;
        e_iok = m_ar && rvalid && !m_data;
      end else begin
        e_awv = !m_aw;
        e_wv  = !m_w;
        e_br  = m_aw && m_w;
        e_dok = m_aw && m_w && bvalid;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, e_iaok});
      chk("data_addr_ok", {31'd0, data_addr_ok}, {31'd0, e_daok});
      chk("arvalid", {31'd0, arvalid}, {31'd0, e_arv});
      chk("rready", {31'd0, rready}, {31'd0, e_rr});
      chk("inst_data_ok", {31'd0, inst_data_ok}, {31'd0, e_iok});
      chk("data_data_ok", {31'd0, data_data_ok}, {31'd0, e_dok});
      chk("awvalid", {31'd0, awvalid}, {31'd0, e_awv});
      chk("wvalid", {31'd0, wvalid}, {31'd0, e_wv});
      chk("bready", {31'd0, bready}, {31'd0, e_br});
      chk("fixed_fields",
          {1'b0, arlen, arburst, arlock, arcache, arprot, awlen, awburst, awlock, awcache, awprot,
           wlast},
          {1'b0, 4'd0, 2'b01, 2'd0, 4'd0, 3'd0, 4'd0, 2'b01, 2'd0, 4'd0, 3'd0, 1'b1});
      if (reset) chk("ids_in_reset", {20'd0, arid, awid, wid}, 32'd0);
      if (e_arv) begin
        chk("araddr", araddr, m_addr);
        chk("arsize", {29'd0, arsize}, {30'd0, m_size});
        chk("arid", {28'd0, arid}, {28'd0, m_data ? DataId : InstId});
      end
      if (e_awv) begin
        chk("awaddr", awaddr, m_addr);
        chk("awsize", {29'd0, awsize}, {30'd0, m_size});
        chk("awid", {28'd0, awid}, {28'd0, DataId});
      end
      if (e_wv) begin
        chk("wdata", wdata, m_wdata);
        chk("wstrb", {28'd0, wstrb}, {28'd0, exp_strb(m_size, m_addr[1:0])});
        chk("wid", {28'd0, wid}, {28'd0, DataId});
      end
      if (e_iok) chk("inst_rdata", inst_rdata, rdata);
      if (e_dok && !m_wr) chk("data_rdata", data_rdata, rdata);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  int ok_cnt;

  initial begin
    // Requests held during reset must not be acknowledged.
    inst_req = 1'b1; data_req = 1'b1; inst_addr = 32'h1000; data_addr = 32'h2000;
    @(posedge clock);
    chk_en = 1'b1;
    @(negedge clock);
    chk("reset_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
    chk("reset_valids", {27'd0, arvalid, awvalid, wvalid, rready, bready}, 32'd0);
    repeat (2) @(posedge clock);

    // Instruction fetch, minimum latency.
    #1; reset = 1'b0; data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'hBFC00000;
    arready = 1'b1; rvalid = 1'b1; rdata = 32'h3C080001;
    @(negedge clock); chk("t027_addr_ok_t0", {31'd0, inst_addr_ok}, 32'd1);
    tick(); inst_req = 1'b0;
    @(negedge clock); chk("t027_arvalid_t1", {31'd0, arvalid}, 32'd1);
    chk("t027_araddr", araddr, 32'hBFC00000);
    @(negedge clock); chk("t027_data_ok_t2", {31'd0, inst_data_ok}, 32'd1);
    chk("t027_rdata", inst_rdata, 32'h3C080001);

    // Simultaneous data and instruction reads: data first.
    tick(); data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h100;
    inst_req = 1'b1; inst_addr = 32'h200;
    @(negedge clock); chk("t028_prio", {30'd0, data_addr_ok, inst_addr_ok}, 32'd2);
    tick(); data_req = 1'b0;
    @(negedge clock); chk("t028_arid_data", {28'd0, arid}, 32'd1);
    @(negedge clock); chk("t028_data_ok", {31'd0, data_data_ok}, 32'd1);
    @(negedge clock); chk("t028_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    tick(); inst_req = 1'b0;
    @(negedge clock); chk("t028_arid_inst", {27'd0, arvalid, arid}, 32'h10);
    @(negedge clock); chk("t028_inst_ok", {31'd0, inst_data_ok}, 32'd1);

    // Byte write at offset 3.
    tick(); arready = 1'b0; rvalid = 1'b0;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_addr = 32'h13;
    data_wdata = 32'hAABBCCDD; awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    @(negedge clock); chk("t029_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    tick(); data_req = 1'b0;
    @(negedge clock); chk("t029_wstrb", {28'd0, wstrb}, 32'h8);
    chk("t029_awsize", {29'd0, awsize}, 32'd0);
    ok_cnt = 0;
    repeat (4) begin
      @(negedge clock);
      ok_cnt += int'(data_data_ok);
    end
    chk("t029_one_data_ok", ok_cnt, 32'd1);

    // Halfword write, awready early, wready late.
    tick(); data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1; data_addr = 32'h22;
    data_wdata = 32'h11223344; awready = 1'b1; wready = 1'b0; bvalid = 1'b1;
    @(negedge clock); chk("t030_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    tick(); data_req = 1'b0;
    @(negedge clock); chk("t030_t1_valids", {30'd0, awvalid, wvalid}, 32'd3);
    chk("t032_wstrb", {28'd0, wstrb}, 32'hC);
    tick(); awready = 1'b0;
    @(negedge clock); chk("t030_t2_valids", {30'd0, awvalid, wvalid}, 32'd1);
    tick();
    @(negedge clock); chk("t030_t3_valids", {30'd0, awvalid, wvalid}, 32'd1);
    tick(); wready = 1'b1;
    @(negedge clock); chk("t030_t4", {29'd0, wvalid, bready, awvalid}, 32'd4);
    tick(); wready = 1'b0;
    @(negedge clock); chk("t030_t5_b", {30'd0, bready, data_data_ok}, 32'd3);
    chk("t032_no_read", {30'd0, arvalid, rready}, 32'd0);

    // Reset while a read waits in the data phase.
    tick(); bvalid = 1'b0; data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2;
    data_addr = 32'h40; arready = 1'b1; rvalid = 1'b0;
    tick(); data_req = 1'b0;
    tick(); arready = 1'b0;
    @(negedge clock); chk("t031_in_r", {31'd0, rready}, 32'd1);
    tick(); reset = 1'b1; rvalid = 1'b1; rdata = 32'hDEAD0001;
    @(negedge clock); chk("t031_abandon", {28'd0, data_data_ok, rready, arvalid, inst_data_ok}, 0);
    tick(); reset = 1'b0; rvalid = 1'b0; inst_req = 1'b1; inst_addr = 32'h300; arready = 1'b1;
    @(negedge clock); chk("t031_accept", {31'd0, inst_addr_ok}, 32'd1);
    tick(); inst_req = 1'b0; rvalid = 1'b1; rdata = 32'h0BADF00D;
    @(negedge clock);
    @(negedge clock); chk("t031_done", {31'd0, inst_data_ok}, 32'd1);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (acc_data) data_req = 1'b0;
      if (acc_inst) inst_req = 1'b0;
      if (reset) reset = 1'b0;
      else reset = ($urandom_range(0, 199) == 0);
      if (!data_req && $urandom_range(0, 2) == 0) begin
        data_req = 1'b1; data_wr = 1'($urandom); data_size = 2'($urandom);
        data_addr = $urandom; data_wdata = $urandom;
      end
      if (!inst_req && $urandom_range(0, 2) == 0) begin
        inst_req = 1'b1; inst_addr = $urandom;
      end
      arready = 1'($urandom); rvalid = 1'($urandom); rdata = $urandom;
      awready = 1'($urandom); wready = 1'($urandom); bvalid = 1'($urandom);
      rid = 4'($urandom); rresp = 2'($urandom); bid = 4'($urandom); bresp = 2'($urandom);
    end
    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_sram_arbiter.md
AXI_SRAM_ARBITER -- requirements
Module: axi_sram_arbiter

Interface
REQ-001 SHALL have parameter INST_ID, default 4'd0: arid driven for instruction reads.
REQ-002 SHALL have parameter DATA_ID, default 4'd1: arid/awid/wid driven for data transactions.
REQ-003 SHALL have port clock, input, 1: sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports inst_req in 1, inst_addr in 32, inst_addr_ok out 1, inst_rdata out 32, inst_data_ok out 1: instruction read port, 32-bit reads only.
REQ-006 SHALL have ports data_req in 1, data_wr in 1, data_size in 2 (0=byte, 1=half, 2=word), data_addr in 32, data_wdata in 32, data_addr_ok out 1, data_rdata out 32, data_data_ok out 1: data read/write port.
REQ-007 SHALL have AXI3 read-address outputs arid 4, araddr 32, arlen 4, arsize 3, arburst 2, arlock 2, arcache 4, arprot 3, arvalid 1, plus input arready 1.
REQ-008 SHALL have AXI3 read-data inputs rid 4, rdata 32, rresp 2, rlast 1, rvalid 1, plus output rready 1.
REQ-009 SHALL have AXI3 write outputs awid 4, awaddr 32, awlen 4, awsize 3, awburst 2, awlock 2, awcache 4, awprot 3, awvalid 1, wid 4, wdata 32, wstrb 4, wlast 1, wvalid 1, bready 1; inputs awready, wready, bid 4, bresp 2, bvalid.

Function
REQ-010 SHALL sequence one single-beat AXI transaction at a time; FSM states IDLE, AR, R, W, B.
REQ-011 In IDLE, data_req SHALL win over inst_req when both are high; the winner's addr_ok pulses high for exactly that cycle, the loser's addr_ok stays 0.
REQ-012 On acceptance, address, size, wdata, write flag and requester SHALL be registered; state -> AR for reads, W for writes, on the next edge.
REQ-013 addr_ok SHALL be 0 in every state other than IDLE.
REQ-014 AR: arvalid=1 with registered address; on arvalid&&arready -> R; arvalid drops the following cycle.
REQ-015 R: rready=1; on rvalid the owner's data_ok=1 and rdata=rdata combinationally in that cycle, non-owner data_ok=0; next state IDLE. rresp and rid are ignored.
REQ-016 W: awvalid and wvalid SHALL assert together; each drops independently after its own handshake; -> B once both handshakes have completed, including the case where both complete in the same cycle.
REQ-017 B: bready=1; on bvalid data_data_ok=1 for one cycle; next state IDLE; bresp is ignored.
REQ-018 Fixed fields: arlen=awlen=0, arburst=awburst=2'b01, lock/cache/prot=0, wlast=1.
REQ-019 arsize/awsize SHALL be {1'b0,size}; inst reads use size 2.
REQ-020 wstrb SHALL be 4'b0001<<addr[1:0] for size 0, addr[1]?4'b1100:4'b0011 for size 1, and 4'b1111 for size 2 or 3.
REQ-021 Address alignment SHALL NOT be checked; addresses are passed through unmodified.
REQ-022 Minimum read latency SHALL be 2 cycles from addr_ok to data_ok (arready and rvalid each high on first opportunity).
REQ-023 Requests SHALL not be queued; the requester holds req until addr_ok.

Reset
REQ-024 While reset=1: state=IDLE, and all valid/ready/ok outputs plus arid, awid and wid SHALL be 0.
REQ-025 Reset asserted mid-transaction SHALL abandon it without a data_ok.
REQ-026 The first request SHALL be accepted in the cycle after reset deasserts.

Verification
REQ-027 inst_req=1, addr=0xBFC00000, arready and rvalid immediately, rdata=0x3C080001 -> addr_ok at T0, arvalid at T1, inst_data_ok with inst_rdata=0x3C080001 at T2.
REQ-028 inst_req and data_req(read) both high in IDLE -> data served first, then inst, with arid=1 then arid=0.
REQ-029 Byte write, addr 0x...3, wdata 0xAABBCCDD -> wstrb=4'b1000, awsize=0, data_data_ok exactly once after bvalid.
REQ-030 Write with awready at T1 but wready delayed to T4 -> awvalid low from T2, wvalid held to T4, B entered at T5.
REQ-031 Reset pulsed while in R with rvalid pending -> no data_ok, all valids 0, next request accepted normally.
REQ-032 Halfword write at addr offset 2 -> wstrb=4'b1100; arvalid/rready stay 0 throughout.
